// File: rtl/banked_mem.sv
// banked_mem: four-bank interleaved word memory. Each bank carries an occupancy
// down-counter; reads return through a fixed-latency registered pipeline.
module banked_mem #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BANK_BUSY = 4,
  parameter int RD_LAT    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_rd,
  input  logic              i_wr,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_out_vld,
  output logic              o_stall,
  output logic [3:0]        o_busy,
  output logic              o_err
);
  localparam int CNT_W = $clog2(BANK_BUSY);
  localparam int ROW_W = ADDR_W - 3;
  localparam int DEPTH = 2 ** ROW_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_BUSY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]  r_cnt [4];
  logic [DATA_W-1:0] r_mem [4][DEPTH];
  logic [RD_LAT-1:0] r_vld;
  logic [DATA_W-1:0] r_dat [RD_LAT];

  logic [1:0]        w_bank;
  logic [ROW_W-1:0]  w_row;
  logic              w_req;
  logic              w_err;
  logic              w_stall;
  logic              w_acc;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [DATA_W-1:0] w_rd_word;

  // Per-bank occupancy flags.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      o_busy[b] = (r_cnt[b] != {CNT_W{1'b0}});
    end
  end

  // Request decode: an illegal request outranks a bank conflict and is dropped.
  always_comb begin
    w_bank    = i_addr[2:1];
    w_row     = i_addr[ADDR_W-1:3];
    w_req     = i_rd ^ i_wr;
    w_err     = (i_rd & i_wr) | ((i_rd | i_wr) & i_addr[0]);
    w_stall   = w_req & ~w_err & o_busy[w_bank];
    w_acc     = w_req & ~w_err & ~w_stall;
    w_rd_acc  = w_acc & i_rd;
    w_wr_acc  = w_acc & i_wr;
    w_rd_word = r_mem[w_bank][w_row];
  end

  assign o_err   = w_err;
  assign o_stall = w_stall;

  // Occupancy counters: only the accepted bank reloads, all others drain.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_rst) begin
        r_cnt[b] <= {CNT_W{1'b0}};
      end else if (w_acc && (w_bank == 2'(b))) begin
        r_cnt[b] <= CNT_LOAD;
      end else if (r_cnt[b] != {CNT_W{1'b0}}) begin
        r_cnt[b] <= r_cnt[b] - CNT_ONE;
      end else begin
        r_cnt[b] <= r_cnt[b];
      end
    end
  end

  // Array write port; contents survive reset, but a write during reset is dropped.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc && !i_rst) begin
      r_mem[w_bank][w_row] <= i_data_in;
    end
  end

  // Read return pipeline; data is zeroed in bubbles so the output is 0 when invalid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        r_dat[i] <= {DATA_W{1'b0}};
      end
    end else begin
      r_vld[0] <= w_rd_acc;
      r_dat[0] <= w_rd_acc ? w_rd_word : {DATA_W{1'b0}};
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_data_out     = r_dat[RD_LAT-1];
  assign o_data_out_vld = r_vld[RD_LAT-1];

endmodule
